mult_div_unit: RTL

Multi-cycle multiply/divide unit with architectural HI/LO registers, living in the E stage next to the ALU. It executes mult, multu, div, divu, mthi and mtlo, and serves HI or LO back to the E-stage result mux for mfhi/mflo. It produces `MULT_Busy` and consumes `MULT_Start`, the two handshake signals the pipeline stall controller uses to hold any D-stage mult/div-class instruction while an operation is in flight.

---
 rtl/mult_div_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit holding the architectural
// HI/LO registers. The result is computed when the operation starts and held
// in P_HI/P_LO. It is copied into HI/LO when the busy countdown expires, so
// reads during RUN always return the previous committed values.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation in flight; accepts Start and mthi/mtlo
// RUN   | countdown active; MULT_Busy high; all inputs ignored
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MULT_Op,
  input  logic        MULT_Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MULT_RD_Sel,
  output logic        MULT_Busy,
  output logic [31:0] MULT_RD
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_next;
  logic [31:0]      hi, lo, p_hi, p_lo;
  logic [CNT_W-1:0] cnt;

  logic is_mul, is_div, launch, commit, mthi_wr, mtlo_wr;
  logic [31:0] res_hi, res_lo;

  // Operation decode; everything here is qualified by IDLE so RUN ignores inputs.
  always_comb begin
    is_mul  = (MULT_Op == OP_MULT) || (MULT_Op == OP_MULTU);
    is_div  = (MULT_Op == OP_DIV)  || (MULT_Op == OP_DIVU);
    launch  = (state == IDLE) && MULT_Start && (is_mul || is_div);
    mthi_wr = (state == IDLE) && (MULT_Op == OP_MTHI);
    mtlo_wr = (state == IDLE) && (MULT_Op == OP_MTLO);
    commit  = (state == RUN) && (cnt == CNT_ONE);
  end

  // Full result of A,B for the selected op. Signed divide works on magnitudes,
  // which also yields 0x80000000 / -1 = 0x80000000 rem 0 without special casing.
  // A zero divisor is replaced by 1 to keep the dividers defined; its result
  // is discarded in favour of the current HI/LO.
  always_comb begin
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, dvs_s, dvs_u, uq_s, ur_s, uq_u, ur_u;
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'd0, A} * {32'd0, B};
    abs_a  = A[31] ? (32'd0 - A) : A;
    abs_b  = B[31] ? (32'd0 - B) : B;
    dvs_s  = (B == 32'd0) ? 32'd1 : abs_b;
    dvs_u  = (B == 32'd0) ? 32'd1 : B;
    uq_s   = abs_a / dvs_s;
    ur_s   = abs_a % dvs_s;
    uq_u   = A / dvs_u;
    ur_u   = A % dvs_u;
    res_hi = hi;
    res_lo = lo;
    case (MULT_Op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: if (B != 32'd0) begin
        res_lo = (A[31] ^ B[31]) ? (32'd0 - uq_s) : uq_s;
        res_hi = A[31] ? (32'd0 - ur_s) : ur_s;
      end
      OP_DIVU: if (B != 32'd0) begin
        res_lo = uq_u;
        res_hi = ur_u;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = RUN;
      RUN:     if (commit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    MULT_Busy = (state == RUN);
    MULT_RD   = MULT_RD_Sel ? hi : lo;
  end

  // Pending result capture, countdown, and HI/LO commit or direct move.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      p_hi <= 32'd0;
      p_lo <= 32'd0;
      cnt  <= '0;
    end else begin
      if (launch) begin
        p_hi <= res_hi;
        p_lo <= res_lo;
        cnt  <= is_mul ? MULT_LOAD : DIV_LOAD;
      end else if (state == RUN) begin
        cnt <= cnt - CNT_ONE;
      end
      if (commit) begin
        hi <= p_hi;
        lo <= p_lo;
      end else begin
        if (mthi_wr) hi <= A;
        if (mtlo_wr) lo <= A;
      end
    end
  end

endmodule
